// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the forwarding / load-use hazard unit.
package hazard_pkg;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Control part of a pipeline-stage entry. The destination register is kept
    // next to it in the stage arrays because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic is_load;
    } stage_ctl_t;

    // Ceiling log2, used to size the per-port forward select.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_port_select.sv
// Per-read-port forwarding priority comparator: picks the youngest post-EX
// stage whose destination matches this port's source register.
module fwd_port_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int SELW   = clog2(DEPTH + 1)
) (
    input  logic [REG_AW-1:0]       rs_i,
    input  logic                    rs_en_i,
    input  logic                    ex_valid_i,
    input  logic [DEPTH-1:0]        src_vld_i,
    input  logic [DEPTH*REG_AW-1:0] src_rd_i,
    output logic [SELW-1:0]         sel_o
);

    // Scan oldest to youngest so the youngest (smallest k) match is left standing.
    always_comb begin
        sel_o = SELW'(FWD_RF);
        if (ex_valid_i && rs_en_i) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (src_vld_i[k-1] && (src_rd_i[(k-1)*REG_AW +: REG_AW] == rs_i)) begin
                    sel_o = SELW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding and load-use hazard unit. Tracks the destination of every issued
// instruction through EX (stage 0) and DEPTH post-EX stages, drives the EX
// operand forward selects and stalls ID when a load result is not yet
// forwardable.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int NRD        = 2,
    parameter  int DEPTH      = 2,
    parameter  int LOAD_STAGE = 2,
    parameter  int CNT_W      = 16,
    localparam int SELW       = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_AW-1:0]     issue_rd,
    input  logic                  issue_regwrite,
    input  logic                  issue_is_load,
    input  logic [NRD*REG_AW-1:0] id_rs,
    input  logic [NRD-1:0]        id_rs_en,
    input  logic                  hold,
    input  logic                  flush,
    output logic [NRD*SELW-1:0]   fwd_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Stage 0 is EX, stages 1..DEPTH are the post-EX stages.
    stage_ctl_t             stg_q   [DEPTH+1];
    stage_ctl_t             stg_d   [DEPTH+1];
    logic [REG_AW-1:0]      rd_q    [DEPTH+1];
    logic [REG_AW-1:0]      rd_d    [DEPTH+1];
    logic [NRD*REG_AW-1:0]  ex_rs_q;
    logic [NRD*REG_AW-1:0]  ex_rs_d;
    logic [NRD-1:0]         ex_rs_en_q;
    logic [NRD-1:0]         ex_rs_en_d;
    logic [CNT_W-1:0]       stall_cnt_q;
    logic [CNT_W-1:0]       stall_cnt_d;

    logic [DEPTH:0]         is_src;
    logic                   load_hazard;
    logic                   capture;
    logic [DEPTH*REG_AW-1:0] post_rd;

    // An entry can forward when it is live, writes a register and that register is not x0.
    always_comb begin
        for (int s = 0; s <= DEPTH; s++) begin
            is_src[s] = stg_q[s].valid & stg_q[s].regwrite & (rd_q[s] != '0);
        end
    end

    // Load-use detection: a load that has not yet reached LOAD_STAGE cannot feed
    // the ID instruction when it enters EX on the next edge.
    always_comb begin
        load_hazard = 1'b0;
        for (int s = 0; s <= DEPTH; s++) begin
            for (int p = 0; p < NRD; p++) begin
                if ((s + 1 < LOAD_STAGE) && is_src[s] && stg_q[s].is_load &&
                    id_rs_en[p] && (id_rs[p*REG_AW +: REG_AW] == rd_q[s])) begin
                    load_hazard = 1'b1;
                end
            end
        end
    end

    assign stall     = issue_valid & ~flush & load_hazard;
    assign capture   = issue_valid & ~stall & ~flush;
    assign stall_cnt = stall_cnt_q;

    // Next state: shift the post-EX stages and fill EX with the ID instruction or a bubble.
    always_comb begin
        stg_d       = stg_q;
        rd_d        = rd_q;
        ex_rs_d     = ex_rs_q;
        ex_rs_en_d  = ex_rs_en_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            for (int k = DEPTH; k >= 1; k--) begin
                stg_d[k] = stg_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            // A flushed EX instruction is killed rather than carried onward.
            if (flush) begin
                stg_d[1].valid = 1'b0;
            end
            stg_d[0].valid    = capture;
            stg_d[0].regwrite = issue_regwrite;
            stg_d[0].is_load  = issue_is_load;
            rd_d[0]           = issue_rd;
            ex_rs_d           = id_rs;
            ex_rs_en_d        = id_rs_en;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // Control state: valid/flags and the stall counter, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DEPTH; k++) begin
                stg_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            stg_q       <= stg_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Register addresses only matter under a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        rd_q       <= rd_d;
        ex_rs_q    <= ex_rs_d;
        ex_rs_en_q <= ex_rs_en_d;
    end

    // Flatten the post-EX destinations for the per-port comparators.
    always_comb begin
        post_rd = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            post_rd[(k-1)*REG_AW +: REG_AW] = rd_q[k];
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_port_select #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SELW   (SELW)
        ) u_sel (
            .rs_i       (ex_rs_q[p*REG_AW +: REG_AW]),
            .rs_en_i    (ex_rs_en_q[p]),
            .ex_valid_i (stg_q[0].valid),
            .src_vld_i  (is_src[DEPTH:1]),
            .src_rd_i   (post_rd),
            .sel_o      (fwd_sel[p*SELW +: SELW])
        );
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core. It registers the destination of every issued instruction and tracks it through the EX stage and the DEPTH post-EX stages. From that state it generates per-read-port forwarding selects for the instruction in EX. It also raises a load-use stall for the instruction in ID and inserts the matching bubble. It sits beside the ID/EX pipeline register and replaces the purely combinational forwarding logic; the datapath muxes consume its selects.

## Interface
Parameters:
- REG_AW, 5, register-address width
- NRD, 2, source read ports per instruction
- DEPTH, 2, post-EX stages that can forward (1 = EX/MEM, 2 = MEM/WB, 3 = WB/late)
- LOAD_STAGE, 2, first post-EX stage index at which load data is forwardable (1..DEPTH)
- CNT_W, 16, stall-counter width
- SELW, derived = clog2(DEPTH+1), forward-select width per port

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  ID holds a valid instruction
- issue_rd  in  REG_AW  ID destination register
- issue_regwrite  in  1  ID instruction writes rd
- issue_is_load  in  1  ID instruction is a load
- id_rs  in  NRD*REG_AW  ID source registers, port p at [p*REG_AW +: REG_AW]
- id_rs_en  in  NRD  source port p is actually read
- hold  in  1  global pipeline freeze (memory wait)
- flush  in  1  kill the ID instruction and the EX-stage entry
- fwd_sel  out  NRD*SELW  per-port select for the EX instruction: 0 = register file, k = post-EX stage k
- stall  out  1  ID must not advance; bubble enters EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- State: stage 0 (EX) plus stages 1..DEPTH. Each entry holds {valid, rd, regwrite, is_load}. Stage 0 also holds rs[NRD] and rs_en[NRD].
- An entry is a forwarding source when valid & regwrite & rd != 0.
- fwd_sel[p]: the smallest k in 1..DEPTH whose stage k is a source with rd == stage0.rs[p]. Requires stage0.valid & stage0.rs_en[p]; otherwise 0. The youngest match wins.
- stall = issue_valid & !flush & OR over p, s of a hazard term.
  - Hazard term: id_rs_en[p] & stage s is a valid load source with rd == id_rs[p] & s+1 < LOAD_STAGE, for s in 0..LOAD_STAGE-2.
- Advance, when !hold:
  - Stages 1..DEPTH shift by one.
  - Stage 0 loads the ID instruction if issue_valid & !stall & !flush; otherwise it loads a bubble (valid = 0).
- flush: the stage-0 entry is invalidated, and the ID instruction is not captured that edge. flush forces stall = 0.
- Invariant: a load in stage k < LOAD_STAGE never matches an EX source. The stall logic guarantees this.
- stall_cnt increments on each edge with stall & !hold and saturates at all-ones.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, fwd_sel = 0, stall = 0, stall_cnt = 0. Effect is immediate, including mid-operation; the first edge after release samples normally.
- fwd_sel and stall are combinational from registered state and current inputs, with zero cycles from input to output.
- Latency from issue to forwardable at stage k is k+1 edges.
- A load-use stall lasts LOAD_STAGE-1 cycles (1 with defaults).
- hold high: no state changes, outputs reflect the frozen state, and stall_cnt is frozen.
- flush and hold together: hold wins, and flush is ignored that cycle.

## Structure
- Shared package hazard_pkg:
  - stage-entry struct
  - FWD_RF = 0
  - select-width function clog2
- One sub-module: fwd_port_select, the per-port priority comparator over DEPTH stages, instantiated NRD times for fwd_sel.

## Test plan
Defaults unless stated.
- Reset: pulse rst_n low mid-stream with entries valid -> all valid cleared, fwd_sel = 0, stall = 0, stall_cnt = 0 asynchronously.
- add x5 then add x6,x5,x0 then sub x7,x5,x5 -> fwd_sel port0 = 1 for the second instruction in EX. For the third instruction, ports 0 and 1 both = 2.
- lw x5 followed by add x6,x5,x1 in ID -> stall = 1 for exactly one cycle and a bubble enters EX. Then fwd_sel port0 = 2 and stall_cnt = 1.
- x5 written in both stage 1 and stage 2 -> fwd_sel = 1. An instruction with rd = x0 and regwrite = 1 -> fwd_sel = 0 for an x0 source.
- Load-use with hold = 1 for 3 cycles -> stall stays 1, no shift, stall_cnt unchanged. Same case with flush = 1 -> stall = 0 and EX gets a bubble.
- DEPTH = 3, LOAD_STAGE = 3: lw x5 then a dependent instruction -> stall for 2 cycles, then fwd_sel = 3.
